// File: rtl/wx_pkg.sv
// wx_pkg: shared states, status codes, field tags and calendar constants for the scheduler.
package wx_pkg;
    localparam int HOURS_PER_DAY = 24;
    typedef enum logic [2:0] {
        OFF    = 3'b000,
        WARMUP = 3'b001,
        SEND_T = 3'b010,
        SEND_H = 3'b011,
        SEND_W = 3'b100,
        WAIT   = 3'b101,
        ABORT  = 3'b110
    } state_t;
    localparam logic [2:0] SIG_OFF    = 3'b000;
    localparam logic [2:0] SIG_WARMUP = 3'b001;
    localparam logic [2:0] SIG_SEND_T = 3'b010;
    localparam logic [2:0] SIG_SEND_H = 3'b011;
    localparam logic [2:0] SIG_SEND_W = 3'b100;
    localparam logic [2:0] SIG_WAIT   = 3'b101;
    localparam logic [2:0] SIG_ABORT  = 3'b110;
    localparam logic [1:0] TAG_TEMP = 2'b01;
    localparam logic [1:0] TAG_HUM  = 2'b10;
    localparam logic [1:0] TAG_WIND = 2'b11;
endpackage

// File: rtl/wx_tx_scheduler_if.sv
// wx_tx_scheduler_if: valid/ready word channel from the scheduler to the transceiver.
interface wx_tx_scheduler_if;
    logic       valid;
    logic       ready;
    logic [1:0] tag;
    logic [5:0] data;
    modport master (output valid, tag, data, input ready);
    modport slave  (input valid, tag, data, output ready);
endinterface

// File: rtl/wx_hour_clock.sv
// wx_hour_clock: hour-of-day counter with load/wrap and reporting-window decode.
module wx_hour_clock
    import wx_pkg::*;
#(
    parameter int WIN_START = 6,
    parameter int WIN_END   = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hour_tick,
    input  logic       hour_load,
    input  logic [4:0] hour_set,
    output logic [4:0] hour,
    output logic       in_window
);
    always_ff @(posedge clk or negedge rst)
        if (!rst) hour <= '0;
        else if (hour_load) hour <= (hour_set >= 5'(HOURS_PER_DAY)) ? '0 : hour_set;
        else if (hour_tick) hour <= (hour == 5'(HOURS_PER_DAY - 1)) ? '0 : hour + 5'd1;
    // A window whose start is after its end wraps through midnight.
    always_comb
        in_window = (WIN_START < WIN_END) ? (hour >= 5'(WIN_START) && hour < 5'(WIN_END)) :
                    (WIN_START > WIN_END) ? (hour >= 5'(WIN_START) || hour < 5'(WIN_END)) : 1'b1;
endmodule

// File: rtl/wx_tx_scheduler.sv
// wx_tx_scheduler: windowed radio enable plus periodic 3-word sensor frame sequencer.
module wx_tx_scheduler
    import wx_pkg::*;
#(
    parameter int WIN_START     = 6,
    parameter int WIN_END       = 20,
    parameter int WARMUP_CYCLES = 8,
    parameter int REPORT_PERIOD = 64,
    parameter int TIMEOUT       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hour_tick,
    input  logic                  hour_load,
    input  logic [4:0]            hour_set,
    input  logic [5:0]            temperature,
    input  logic [5:0]            humidity,
    input  logic [4:0]            wind,
    wx_tx_scheduler_if.master     tx,
    output logic [4:0]            current_hour,
    output logic                  enable_transceiver,
    output logic [2:0]            signal,
    output logic [7:0]            drop_cnt
);
    state_t      state, nxt;
    logic [15:0] cnt, cnt_n;
    logic [5:0]  snap_t, snap_h, snap_t_n, snap_h_n;
    logic [4:0]  snap_w, snap_w_n;
    logic [1:0]  tag_n;
    logic [5:0]  data_n;
    logic        in_window, xfer, snap_load;

    wx_hour_clock #(.WIN_START(WIN_START), .WIN_END(WIN_END)) u_hour (
        .clk(clk), .rst(rst), .hour_tick(hour_tick), .hour_load(hour_load),
        .hour_set(hour_set), .hour(current_hour), .in_window(in_window)
    );

    assign xfer   = tx.valid && tx.ready;
    assign signal = state;

    // One shared counter times warmup, report period and handshake timeout.
    always_comb begin
        nxt       = state;
        snap_load = 1'b0;
        case (state)
            OFF:    if (in_window) nxt = WARMUP;
            WARMUP: if (!in_window) nxt = OFF;
                    else if (cnt == 16'(WARMUP_CYCLES - 1)) begin nxt = SEND_T; snap_load = 1'b1; end
            SEND_T: nxt = xfer ? SEND_H : (cnt == 16'(TIMEOUT - 1)) ? ABORT : SEND_T;
            SEND_H: nxt = xfer ? SEND_W : (cnt == 16'(TIMEOUT - 1)) ? ABORT : SEND_H;
            SEND_W: nxt = xfer ? (in_window ? WAIT : OFF) : (cnt == 16'(TIMEOUT - 1)) ? ABORT : SEND_W;
            WAIT:   if (!in_window) nxt = OFF;
                    else if (cnt == 16'(REPORT_PERIOD - 1)) begin nxt = SEND_T; snap_load = 1'b1; end
            ABORT:  nxt = in_window ? WAIT : OFF;
            default: nxt = OFF;
        endcase
        cnt_n    = (nxt != state || xfer) ? '0 : cnt + 16'd1;
        snap_t_n = snap_load ? temperature : snap_t;
        snap_h_n = snap_load ? humidity : snap_h;
        snap_w_n = snap_load ? wind : snap_w;
        tag_n    = nxt == SEND_T ? TAG_TEMP : nxt == SEND_H ? TAG_HUM : nxt == SEND_W ? TAG_WIND : 2'b00;
        data_n   = nxt == SEND_T ? snap_t_n : nxt == SEND_H ? snap_h_n : nxt == SEND_W ? {1'b0, snap_w_n} : 6'd0;
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state              <= OFF;
            cnt                <= '0;
            snap_t             <= '0;
            snap_h             <= '0;
            snap_w             <= '0;
            enable_transceiver <= 1'b0;
            tx.valid           <= 1'b0;
            tx.tag             <= '0;
            tx.data            <= '0;
            drop_cnt           <= '0;
        end else begin
            state              <= nxt;
            cnt                <= cnt_n;
            snap_t             <= snap_t_n;
            snap_h             <= snap_h_n;
            snap_w             <= snap_w_n;
            enable_transceiver <= nxt != OFF;
            tx.valid           <= nxt == SEND_T || nxt == SEND_H || nxt == SEND_W;
            tx.tag             <= tag_n;
            tx.data            <= data_n;
            if (nxt == ABORT && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
        end
endmodule

// File: tb/tb_wx_tx_scheduler.sv
// tb_wx_tx_scheduler: directed checks of hour window, frame sequencing, stall, timeout and reset.
module tb_wx_tx_scheduler;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       hour_tick = 1'b0, hour_load = 1'b0;
    logic [4:0] hour_set = '0;
    logic [5:0] temperature = '0, humidity = '0;
    logic [4:0] wind = '0;
    logic [4:0] hour_a, hour_b;
    logic       en_a, en_b;
    logic [2:0] sig_a, sig_b;
    logic [7:0] drop_a, drop_b;
    int         checks = 0, fails = 0;

    wx_tx_scheduler_if txa ();
    wx_tx_scheduler_if txb ();

    wx_tx_scheduler dut_a (
        .clk(clk), .rst(rst), .hour_tick(hour_tick), .hour_load(hour_load), .hour_set(hour_set),
        .temperature(temperature), .humidity(humidity), .wind(wind), .tx(txa),
        .current_hour(hour_a), .enable_transceiver(en_a), .signal(sig_a), .drop_cnt(drop_a)
    );

    wx_tx_scheduler #(.WIN_START(22), .WIN_END(2)) dut_b (
        .clk(clk), .rst(rst), .hour_tick(hour_tick), .hour_load(hour_load), .hour_set(hour_set),
        .temperature(temperature), .humidity(humidity), .wind(wind), .tx(txb),
        .current_hour(hour_b), .enable_transceiver(en_b), .signal(sig_b), .drop_cnt(drop_b)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        txa.ready = 1'b0;
        txb.ready = 1'b1;
        tick();
        chk("rst_hour", 32'(hour_a), 0);
        chk("rst_en", 32'(en_a), 0);
        chk("rst_sig", 32'(sig_a), 0);
        chk("rst_valid", 32'(txa.valid), 0);
        chk("rst_tag", 32'(txa.tag), 0);
        chk("rst_data", 32'(txa.data), 0);
        chk("rst_drop", 32'(drop_a), 0);
        rst = 1'b1;
        hour_load = 1'b1; hour_set = 5'd5;
        tick();
        hour_load = 1'b0;
        chk("load5_hour", 32'(hour_a), 5);
        chk("load5_en", 32'(en_a), 0);
        chk("load5_sig", 32'(sig_a), 0);
        hour_tick = 1'b1;
        tick();
        hour_tick = 1'b0;
        chk("tick6_hour", 32'(hour_a), 6);
        chk("tick6_en_lag", 32'(en_a), 0);
        tick();
        chk("warm_en", 32'(en_a), 1);
        chk("warm_sig", 32'(sig_a), 1);
        temperature = 6'h2a; humidity = 6'h15; wind = 5'h1f; txa.ready = 1'b1;
        repeat (7) tick();
        chk("warm_last", 32'(sig_a), 1);
        tick();
        chk("t_sig", 32'(sig_a), 2);
        chk("t_valid", 32'(txa.valid), 1);
        chk("t_tag", 32'(txa.tag), 1);
        chk("t_data", 32'(txa.data), 6'h2a);
        temperature = 6'd3; humidity = 6'd4; wind = 5'd5;
        tick();
        chk("h_tag", 32'(txa.tag), 2);
        chk("h_data_snap", 32'(txa.data), 6'h15);
        tick();
        chk("w_tag", 32'(txa.tag), 3);
        chk("w_data_zext", 32'(txa.data), 6'h1f);
        tick();
        chk("wait_sig", 32'(sig_a), 5);
        chk("wait_valid", 32'(txa.valid), 0);
        repeat (63) tick();
        chk("wait_last", 32'(sig_a), 5);
        tick();
        chk("t2_sig", 32'(sig_a), 2);
        chk("t2_data", 32'(txa.data), 6'd3);
        txa.ready = 1'b0; temperature = 6'd9;
        repeat (5) tick();
        chk("stall_sig", 32'(sig_a), 2);
        chk("stall_valid", 32'(txa.valid), 1);
        chk("stall_tag", 32'(txa.tag), 1);
        chk("stall_data", 32'(txa.data), 6'd3);
        txa.ready = 1'b1;
        tick();
        chk("h2_data", 32'(txa.data), 6'd4);
        txa.ready = 1'b0;
        repeat (15) tick();
        chk("to_last_h", 32'(sig_a), 3);
        tick();
        chk("abort_sig", 32'(sig_a), 6);
        chk("abort_valid", 32'(txa.valid), 0);
        chk("abort_drop", 32'(drop_a), 1);
        tick();
        chk("abort_wait", 32'(sig_a), 5);
        chk("drop_hold", 32'(drop_a), 1);
        hour_load = 1'b1; hour_set = 5'd19; txa.ready = 1'b1;
        tick();
        hour_load = 1'b0;
        repeat (62) tick();
        chk("h19_wait", 32'(sig_a), 5);
        tick();
        chk("t3_sig", 32'(sig_a), 2);
        tick();
        chk("h3_sig", 32'(sig_a), 3);
        hour_tick = 1'b1; txa.ready = 1'b0;
        tick();
        hour_tick = 1'b0;
        chk("close_hour", 32'(hour_a), 20);
        chk("close_keep_h", 32'(sig_a), 3);
        chk("close_keep_en", 32'(en_a), 1);
        txa.ready = 1'b1;
        tick();
        chk("close_w_sig", 32'(sig_a), 4);
        chk("close_w_data", 32'(txa.data), 6'd5);
        tick();
        chk("close_off_sig", 32'(sig_a), 0);
        chk("close_off_en", 32'(en_a), 0);
        hour_load = 1'b1; hour_set = 5'd23;
        tick();
        hour_load = 1'b0;
        chk("h23", 32'(hour_b), 23);
        tick();
        chk("b_en23", 32'(en_b), 1);
        chk("a_off23", 32'(en_a), 0);
        hour_tick = 1'b1;
        tick();
        hour_tick = 1'b0;
        chk("wrap0", 32'(hour_a), 0);
        tick();
        chk("b_en0", 32'(en_b), 1);
        hour_load = 1'b1; hour_tick = 1'b1; hour_set = 5'd10;
        tick();
        hour_load = 1'b0; hour_tick = 1'b0;
        chk("load_wins", 32'(hour_a), 10);
        txa.ready = 1'b0;
        repeat (9) tick();
        chk("t4_sig", 32'(sig_a), 2);
        #2 rst = 1'b0;
        #1;
        chk("arst_sig", 32'(sig_a), 0);
        chk("arst_valid", 32'(txa.valid), 0);
        chk("arst_en", 32'(en_a), 0);
        chk("arst_hour", 32'(hour_a), 0);
        chk("arst_drop", 32'(drop_a), 0);
        chk("arst_data", 32'(txa.data), 0);
        tick();
        rst = 1'b1;
        hour_load = 1'b1; hour_set = 5'd12;
        tick();
        chk("load12", 32'(hour_a), 12);
        hour_set = 5'd30;
        tick();
        hour_load = 1'b0;
        chk("load30", 32'(hour_a), 0);
        chk("no_resume", 32'(sig_a), 1);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule

// File: doc/wx_tx_scheduler.md
Name: wx_tx_scheduler

Overview:
Time-of-day scheduler and frame sequencer for the weather-station transceiver.
- Keeps the hour of day and asserts enable_transceiver only inside a configured reporting window.
- While enabled, it warms up the radio, then periodically snapshots temperature, humidity and wind.
- Each snapshot is sent as a 3-word frame over a valid/ready handshake, with a timeout and drop counting.
- Sits between the sensor front-end/RTC tick and the transceiver datapath.

Parameters:
WIN_START, 6, first hour (0-23) of the enable window, inclusive
WIN_END, 20, hour (0-23) at which the window closes, exclusive; WIN_START==WIN_END means always enabled
WARMUP_CYCLES, 8, cycles from enable rising to the first snapshot
REPORT_PERIOD, 64, cycles from the end of one frame to the next snapshot
TIMEOUT, 16, maximum cycles tx_valid may wait for tx_ready before the frame is aborted

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
hour_tick  in  1  one-cycle pulse, advance hour by one
hour_load  in  1  load hour_set into the hour counter (wins over hour_tick)
hour_set  in  5  hour to load; values >23 load 0
temperature  in  6  sensor reading
humidity  in  6  sensor reading
wind  in  5  sensor reading
tx_ready  in  1  transceiver accepts the current word
current_hour  out  5  hour counter, 0-23
enable_transceiver  out  1  transceiver power/enable
signal  out  3  status code (see Behaviour)
tx_valid  out  1  word valid
tx_tag  out  2  field id: 01 temp, 10 humidity, 11 wind
tx_data  out  6  word payload; wind is zero-extended
drop_cnt  out  8  aborted-frame counter, saturates at 255

Behaviour:
- Reset (rst==0, asynchronous): current_hour=0, enable_transceiver=0, signal=000, tx_valid=0, tx_tag=00, tx_data=0, drop_cnt=0, FSM=OFF, all counters=0.
- Hour counter: hour_load loads hour_set, or 0 if hour_set>23. Otherwise hour_tick increments, wrapping 23->0. The counter updates at the clock edge after the input.
- in_window (combinational on the registered hour):
  - WIN_START<WIN_END: hour>=WIN_START && hour<WIN_END.
  - WIN_START>WIN_END: hour>=WIN_START || hour<WIN_END.
  - equal: always 1.
- enable_transceiver is registered. It equals 1 in every state except OFF, so it rises one cycle after in_window rises.
- FSM states and signal codes: OFF 000, WARMUP 001, SEND_T 010, SEND_H 011, SEND_W 100, WAIT 101, ABORT 110.
- OFF -> WARMUP when in_window. Warmup counter clears on entry.
- WARMUP: count WARMUP_CYCLES cycles. If !in_window, go to OFF immediately. Otherwise go to SEND_T, latching a snapshot of all three sensors on the transition edge.
- SEND_T/H/W:
  - tx_valid=1; tx_tag and tx_data are driven from the snapshot, never from live sensor inputs.
  - A word transfers on a cycle with tx_valid&&tx_ready; the next state follows on the next edge.
  - tx_data and tx_tag are stable while tx_valid && !tx_ready.
  - The timeout counter resets on each transfer. On reaching TIMEOUT cycles without tx_ready, go to ABORT.
- SEND_W transfer -> WAIT (or OFF if !in_window at that edge).
- Window closing mid-frame: the frame always completes (or aborts). It is never truncated by in_window falling.
- WAIT: count REPORT_PERIOD cycles, then re-snapshot and go to SEND_T. If !in_window, go to OFF immediately.
- ABORT: lasts one cycle with tx_valid=0 and drop_cnt incremented (saturating). Then go to WAIT, or OFF if !in_window.
- Simultaneous hour_load and hour_tick: hour_load wins.
- Reset asserted mid-frame: all outputs return to reset values asynchronously. No partial frame resumes after reset.

Decomposition:
- Package wx_pkg holds:
  - the state enum and signal code constants (OFF..ABORT);
  - tx_tag constants TAG_TEMP=01, TAG_HUM=10, TAG_WIND=11;
  - HOURS_PER_DAY=24.
- Sub-module wx_hour_clock: hour counter, load/wrap logic and in_window comparison, parameterised by WIN_START/WIN_END.

Test Plan:
- Reset, then hour_load with hour_set=5 -> current_hour=5, enable=0, signal=000. One hour_tick -> hour 6; enable=1 and signal=001 one cycle later.
- Enabled, tx_ready tied 1 -> after 8 warmup cycles, three consecutive tx_valid cycles with tags 01/10/11 and data = temperature/humidity/{0,wind} sampled at snapshot. Signal goes 101 for 64 cycles, then the next frame starts.
- Sensors changing during a frame with tx_ready stalled 5 cycles -> tx_data holds the snapshot values and remains stable while stalled.
- tx_ready held 0 in SEND_H for 16 cycles -> ABORT (signal=110) for one cycle, drop_cnt=1, then WAIT.
- Window closes during SEND_H (hour_tick 19->20) -> SEND_W still completes, then OFF and enable=0. Separately, hour_tick at 23 -> 0, and with WIN_START=22, WIN_END=2 -> enable stays 1.
- rst pulsed low mid-SEND_T -> all outputs 0 immediately. hour_set=30 loads 0.
